// File: rtl/dram_bus_master_if.sv
// dram_bus_master_if: request handshake plus multiplexed DRAM strobe/address bus.
interface dram_bus_master_if;
  logic        req;
  logic        we_req;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  maddress;
  logic        _ras;
  logic        _cas;
  logic        _we;
  modport master (
    input  req, we_req, addr, wdata,
    output ack, rdata, busy, maddress, _ras, _cas, _we
  );
  modport slave (
    output req, we_req, addr, wdata,
    input  ack, rdata, busy, maddress, _ras, _cas, _we
  );
endinterface

// File: rtl/dram_bus_master.sv
// dram_bus_master: turns flat 16-bit requests into early-write RAS/CAS DRAM cycles.
// Define ULTIMEM_REFRESH_EN to add periodic RAS-only refresh.
module dram_bus_master #(
  parameter int T_ASR = 1,
  parameter int T_RCD = 2,
  parameter int T_CAS = 3,
  parameter int T_RP  = 2
`ifdef ULTIMEM_REFRESH_EN
  , parameter int REF_INTV = 64
`endif
) (
  input  logic              clock,
  input  logic              _reset,
  dram_bus_master_if.master bus,
  inout  wire  [7:0]        data
);
  typedef enum logic [2:0] {IDLE, ROW, RAS, COL, CAS, PRE
`ifdef ULTIMEM_REFRESH_EN
    , RFS
`endif
  } state_e;
  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d, lim;
  logic       we_q, we_d;
  logic [7:0] col_q, col_d, wdata_q, wdata_d, maddr_q, maddr_d, rdata_q, rdata_d;
  logic       last, drive, ras_n;
`ifdef ULTIMEM_REFRESH_EN
  logic        ref_q, ref_d, pend_q, pend_d, expire;
  logic [7:0]  row_q, row_d;
  logic [15:0] tick_q, tick_d;
`else
  logic        ref_q;
  assign ref_q = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    col_d   = col_q;
    wdata_d = wdata_q;
    maddr_d = maddr_q;
    rdata_d = rdata_q;
`ifdef ULTIMEM_REFRESH_EN
    ref_d  = ref_q;
    row_d  = row_q;
    expire = tick_q == 16'(REF_INTV - 1);
    tick_d = expire ? '0 : tick_q + 16'd1;
    pend_d = pend_q | expire;
`endif
    case (state_q)
      ROW:     lim = 5'(T_ASR - 1);
      RAS:     lim = 5'(T_RCD - 1);
      CAS:     lim = 5'(T_CAS - 1);
      PRE:     lim = 5'(T_RP - 1);
`ifdef ULTIMEM_REFRESH_EN
      RFS:     lim = 5'(T_RCD + T_CAS - 1);
`endif
      default: lim = '0;
    endcase
    last  = cnt_q == lim;
    cnt_d = last ? '0 : cnt_q + 5'd1;
    ras_n = !(state_q inside {RAS, COL, CAS});
`ifdef ULTIMEM_REFRESH_EN
    ras_n = ras_n & (state_q != RFS);
`endif
    case (state_q)
      IDLE:
`ifdef ULTIMEM_REFRESH_EN
        // a pending refresh wins over a simultaneous request
        if (pend_q) begin
          state_d = ROW;
          ref_d   = 1'b1;
          we_d    = 1'b0;
          maddr_d = row_q;
          pend_d  = expire;
        end else
`endif
        if (bus.req) begin
          state_d = ROW;
          we_d    = bus.we_req;
          col_d   = bus.addr[15:8];
          wdata_d = bus.wdata;
          maddr_d = bus.addr[7:0];
`ifdef ULTIMEM_REFRESH_EN
          ref_d   = 1'b0;
`endif
        end
`ifdef ULTIMEM_REFRESH_EN
      ROW: if (last) state_d = ref_q ? RFS : RAS;
      RFS: if (last) begin
        state_d = PRE;
        row_d   = row_q + 8'd1;
      end
`else
      ROW: if (last) state_d = RAS;
`endif
      RAS: if (last) begin
        state_d = COL;
        maddr_d = col_q;
      end
      COL: state_d = CAS;
      CAS: if (last) begin
        state_d = PRE;
        if (!we_q) rdata_d = data;
      end
      PRE: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      col_q   <= '0;
      wdata_q <= '0;
      maddr_q <= '0;
      rdata_q <= '0;
`ifdef ULTIMEM_REFRESH_EN
      ref_q   <= 1'b0;
      pend_q  <= 1'b0;
      row_q   <= '0;
      tick_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      col_q   <= col_d;
      wdata_q <= wdata_d;
      maddr_q <= maddr_d;
      rdata_q <= rdata_d;
`ifdef ULTIMEM_REFRESH_EN
      ref_q   <= ref_d;
      pend_q  <= pend_d;
      row_q   <= row_d;
      tick_q  <= tick_d;
`endif
    end
  end
  assign drive        = we_q && (state_q == COL || state_q == CAS);
  assign data         = drive ? wdata_q : 8'hzz;
  assign bus._ras     = ras_n;
  assign bus._cas     = state_q != CAS;
  assign bus._we      = !drive;
  assign bus.busy     = state_q != IDLE;
  assign bus.ack      = state_q == PRE && cnt_q == '0 && !ref_q;
  assign bus.maddress = maddr_q;
  assign bus.rdata    = rdata_q;
endmodule
